wfg_core: RTL and testbench

WFG_CORE -- requirements
Module: wfg_core

---
 rtl/wfg_core.sv | 151 +++++++++++++++
 tb/tb_wfg_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_core.sv
// -----------------------------------------------------------------------------
// wfg_core -- waveform generator timing core with a Wishbone slave.
//
// Generates two timing strobes from a programmable two-level divider:
//   - a subcycle tick every (S+1) clocks
//   - a sync tick on every (N+1)-th subcycle tick
// S, N and the enable bit are written over a minimal Wishbone slave.
//
// Register map (io_wbs_adr[3:2]):
//   0 CTRL          bit0 = en
//   1 SUBCYCLE_CNT  [CNTW-1:0] = S
//   2 SYNC_CNT      [CNTW-1:0] = N
//   3 unmapped      reads 0, writes ignored (still acknowledged)
//
// Ports:
//   io_wbs_clk               clock, all state on rising edge
//   io_wbs_rst_n             asynchronous active-low reset
//   io_wbs_adr/datwr/we/stb/cyc  Wishbone slave inputs
//   io_wbs_datrd/ack         Wishbone slave outputs (datrd is 0 unless ack=1)
//   wfg_core_en_o            CTRL.en, straight from the register
//   wfg_core_subcycle_o      one-clock subcycle tick
//   wfg_core_sync_o          one-clock sync tick (coincides with a subcycle tick)
//   wfg_core_subcycle_cnt_o  current sync counter value
// -----------------------------------------------------------------------------
module wfg_core #(
    parameter int BUSW = 32,
    parameter int CNTW = 8
) (
    input  logic            io_wbs_clk,
    input  logic            io_wbs_rst_n,
    input  logic [BUSW-1:0] io_wbs_adr,
    input  logic [BUSW-1:0] io_wbs_datwr,
    output logic [BUSW-1:0] io_wbs_datrd,
    input  logic            io_wbs_we,
    input  logic            io_wbs_stb,
    input  logic            io_wbs_cyc,
    output logic            io_wbs_ack,
    output logic            wfg_core_en_o,
    output logic            wfg_core_subcycle_o,
    output logic            wfg_core_sync_o,
    output logic [CNTW-1:0] wfg_core_subcycle_cnt_o
);

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_SUB  = 2'd1,
        REG_SYNC = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_e;

    // Configuration registers
    logic            en;
    logic [CNTW-1:0] sub_max;   // S
    logic [CNTW-1:0] sync_max;  // N

    // Divider state
    logic [CNTW-1:0] sc;
    logic [CNTW-1:0] yc;
    logic            sub_q;
    logic            sync_q;

    // Bus decode
    reg_sel_e        sel;
    logic            accept;
    logic [BUSW-1:0] rdata;

    // Divider events for the current cycle
    logic            sub_ev;
    logic            sync_ev;

    // Address bits outside [3:2] and data bits above the field widths are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{io_wbs_adr[BUSW-1:4], io_wbs_adr[1:0],
                           io_wbs_datwr[BUSW-1:CNTW]};

    assign sel    = reg_sel_e'(io_wbs_adr[3:2]);
    // The ~ack term makes a held strobe acknowledge every second cycle.
    assign accept = io_wbs_cyc & io_wbs_stb & ~io_wbs_ack;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL: rdata[0]        = en;
            REG_SUB:  rdata[CNTW-1:0] = sub_max;
            REG_SYNC: rdata[CNTW-1:0] = sync_max;
            default:  rdata           = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            io_wbs_ack   <= 1'b0;
            io_wbs_datrd <= '0;
            en           <= 1'b0;
            sub_max      <= '0;
            sync_max     <= '0;
        end else begin
            io_wbs_ack   <= accept;
            // Read data is captured only for an accepted read, so datrd
            // falls back to 0 as soon as ack drops.
            io_wbs_datrd <= (accept && !io_wbs_we) ? rdata : '0;
            if (accept && io_wbs_we) begin
                case (sel)
                    REG_CTRL: en       <= io_wbs_datwr[0];
                    REG_SUB:  sub_max  <= io_wbs_datwr[CNTW-1:0];
                    REG_SYNC: sync_max <= io_wbs_datwr[CNTW-1:0];
                    default:  ;
                endcase
            end
        end
    end

    // ">=" rather than "==" so a shrinking S or N rolls over immediately
    // instead of counting up to the top of the counter range.
    assign sub_ev  = (sc >= sub_max);
    assign sync_ev = sub_ev && (yc >= sync_max);

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            sc     <= '0;
            yc     <= '0;
            sub_q  <= 1'b0;
            sync_q <= 1'b0;
        end else if (!en) begin
            sc     <= '0;
            yc     <= '0;
            sub_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sub_q  <= sub_ev;
            sync_q <= sync_ev;
            sc     <= sub_ev ? '0 : sc + CNTW'(1);
            if (sub_ev) begin
                yc <= sync_ev ? '0 : yc + CNTW'(1);
            end
        end
    end

    // Gating with en blanks a pulse that was generated on the same edge that
    // cleared the enable bit.
    assign wfg_core_en_o           = en;
    assign wfg_core_subcycle_o     = sub_q & en;
    assign wfg_core_sync_o         = sync_q & en;
    assign wfg_core_subcycle_cnt_o = yc;

endmodule

// File: tb/tb_wfg_core.sv
// -----------------------------------------------------------------------------
// tb_wfg_core -- self-checking bench for wfg_core.
//
// A behavioural model of the register file and the two-level divider is kept
// as plain integers and stepped once per clock; every DUT output is compared
// against it on the falling edge. Directed sections add explicit pulse-timing
// expectations, then a randomized phase mixes reads, writes, held strobes and
// idle periods.
// -----------------------------------------------------------------------------
module tb_wfg_core;

    localparam int BUSW = 32;
    localparam int CNTW = 8;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk;
    logic            rst_n;
    logic [BUSW-1:0] adr;
    logic [BUSW-1:0] datwr;
    logic [BUSW-1:0] datrd;
    logic            we;
    logic            stb;
    logic            cyc;
    logic            ack;
    logic            en_o;
    logic            sub_o;
    logic            sync_o;
    logic [CNTW-1:0] cnt_o;

    wfg_core #(.BUSW(BUSW), .CNTW(CNTW)) dut (
        .io_wbs_clk              (clk),
        .io_wbs_rst_n            (rst_n),
        .io_wbs_adr              (adr),
        .io_wbs_datwr            (datwr),
        .io_wbs_datrd            (datrd),
        .io_wbs_we               (we),
        .io_wbs_stb              (stb),
        .io_wbs_cyc              (cyc),
        .io_wbs_ack              (ack),
        .wfg_core_en_o           (en_o),
        .wfg_core_subcycle_o     (sub_o),
        .wfg_core_sync_o         (sync_o),
        .wfg_core_subcycle_cnt_o (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int          m_en, m_s, m_n;   // registers
    int          m_sc, m_yc;       // cycles into subcycle, subcycles into sync
    bit          m_sub, m_sync, m_ack;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_s = 0; m_n = 0; m_sc = 0; m_yc = 0;
        m_sub = 0; m_sync = 0; m_ack = 0; m_rd = 0;
    endtask

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return 32'(m_en);
            1: return 32'(m_s);
            2: return 32'(m_n);
            default: return 32'd0;
        endcase
    endfunction

    // One clock of the model: counters use the configuration in force before
    // the edge; a write then updates the register file.
    task automatic model_step(input bit c, input bit s, input bit w,
                              input logic [31:0] a, input logic [31:0] d);
        bit acc;
        int idx;
        acc = c && s && !m_ack;
        idx = int'(a[3:2]);
        if (m_en == 0) begin
            m_sc = 0; m_yc = 0; m_sub = 0; m_sync = 0;
        end else begin
            m_sub  = (m_sc >= m_s);
            m_sync = m_sub && (m_yc >= m_n);
            if (m_sub) begin
                m_sc = 0;
                m_yc = m_sync ? 0 : m_yc + 1;
            end else begin
                m_sc = m_sc + 1;
            end
        end
        m_rd = (acc && !w) ? model_read(idx) : 32'd0;
        if (acc && w) begin
            case (idx)
                0: m_en = int'(d[0]);
                1: m_s  = int'(d & CMAX);
                2: m_n  = int'(d & CMAX);
                default: ;
            endcase
        end
        m_ack = acc;
    endtask

    task automatic compare_all();
        check("ack",      ack,    m_ack);
        check("datrd",    datrd,  m_rd);
        check("en_o",     en_o,   m_en[0]);
        check("subcycle", sub_o,  m_sub && (m_en != 0));
        check("sync",     sync_o, m_sync && (m_en != 0));
        check("sync_cnt", cnt_o,  m_yc);
    endtask

    // Called on a falling edge: drive, clock, step model, compare.
    task automatic bus_cycle(input bit c, input bit s, input bit w,
                             input logic [31:0] a, input logic [31:0] d);
        cyc = c; stb = s; we = w; adr = a; datwr = d;
        @(posedge clk);
        model_step(c, s, w, a, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        bus_cycle(1, 1, 1, a, d);
        idle(1);
    endtask

    task automatic wb_read(input logic [31:0] a);
        bus_cycle(1, 1, 0, a, 32'd0);
        idle(1);
    endtask

    initial begin
        int k;
        int budget;
        model_reset();
        rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = '0; datwr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Reset values of all registers
        wb_read(32'h0);
        wb_read(32'h4);
        wb_read(32'h8);

        // Single write of S, readback, unmapped read
        bus_cycle(1, 1, 1, 32'h4, 32'h3);
        check("wr_ack_hi", ack, 1'b1);
        idle(1);
        check("wr_ack_lo", ack, 1'b0);
        bus_cycle(1, 1, 0, 32'h4, 32'h0);
        check("rd_s", datrd, 32'h3);
        idle(1);
        bus_cycle(1, 1, 0, 32'hC, 32'h0);
        check("rd_unmapped", datrd, 32'h0);
        idle(1);
        wb_write(32'hC, 32'hFFFF_FFFF);
        wb_read(32'hC);

        // Held strobe: acked every second cycle
        for (int i = 0; i < 6; i++) begin
            bus_cycle(1, 1, 0, 32'h4, 32'h0);
            check("held_ack", ack, (i % 2 == 0));
        end
        idle(2);

        // S=3, N=1: subcycle every 4 cycles, sync every 8
        wb_write(32'h8, 32'h1);
        bus_cycle(1, 1, 1, 32'h0, 32'h1);
        for (k = 0; k <= 17; k++) begin
            check("per_sub",  sub_o,  (k > 0) && (k % 4 == 0));
            check("per_sync", sync_o, (k > 0) && (k % 8 == 0));
            idle(1);
        end
        wb_write(32'h0, 32'h0);
        idle(2);

        // S=0, N=0: both strobes held high from the cycle after enable
        wb_write(32'h4, 32'h0);
        wb_write(32'h8, 32'h0);
        bus_cycle(1, 1, 1, 32'h0, 32'h1);
        for (k = 0; k <= 6; k++) begin
            check("cont_sub",  sub_o,  k >= 1);
            check("cont_sync", sync_o, k >= 1);
            idle(1);
        end
        wb_write(32'h0, 32'h0);
        idle(2);

        // S=10 running, shrink to S=2 while sc=7
        wb_write(32'h4, 32'd10);
        wb_write(32'h0, 32'h1);
        budget = 0;
        while (m_sc != 7 && budget < 40) begin
            idle(1);
            budget++;
        end
        check("sc7_reached", budget < 40, 1'b1);
        bus_cycle(1, 1, 1, 32'h4, 32'd2);
        for (k = 0; k <= 8; k++) begin
            check("reconf_sub", sub_o, (k == 1) || (k == 4) || (k == 7));
            idle(1);
        end

        // Disable mid-period, then re-enable with S=5
        wb_write(32'h4, 32'd5);
        idle(8);
        bus_cycle(1, 1, 1, 32'h0, 32'h0);
        for (k = 0; k < 8; k++) begin
            check("dis_sub",  sub_o,  1'b0);
            check("dis_sync", sync_o, 1'b0);
            idle(1);
        end
        bus_cycle(1, 1, 1, 32'h0, 32'h1);
        for (k = 0; k <= 12; k++) begin
            check("reen_sub", sub_o, (k > 0) && (k % 6 == 0));
            idle(1);
        end

        // Asynchronous reset in the middle of an access
        cyc = 1; stb = 1; we = 0; adr = 32'h4;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ack",   ack,    1'b0);
        check("rst_datrd", datrd,  32'h0);
        check("rst_en",    en_o,   1'b0);
        check("rst_sub",   sub_o,  1'b0);
        check("rst_sync",  sync_o, 1'b0);
        check("rst_cnt",   cnt_o,  '0);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        cyc = 0; stb = 0;
        rst_n = 1'b1;
        idle(2);
        wb_read(32'h4);

        // Randomized phase
        for (int op = 0; op < 400; op++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            d = $urandom & ~32'(CMAX);
            case (r)
                0, 1: wb_write({$urandom} & 32'hFFFF_FFF3 | 32'h4, d | 32'($urandom_range(0, 5)));
                2:    wb_write({$urandom} & 32'hFFFF_FFF3 | 32'h8, d | 32'($urandom_range(0, 3)));
                3:    wb_write({$urandom} & 32'hFFFF_FFF3, {$urandom} & ~32'h1 | 32'($urandom_range(0, 3) != 0));
                4:    wb_write({$urandom} & 32'hFFFF_FFF3 | 32'hC, {$urandom});
                5, 6: wb_read($urandom);
                7:    for (int i = 0; i < 4; i++) bus_cycle(1, 1, $urandom_range(0, 1) == 0, 32'h4 | (32'($urandom_range(0, 1)) << 3), 32'($urandom_range(0, 4)));
                default: idle($urandom_range(1, 10));
            endcase
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
